// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: turns one 256-bit line read/write from the cache side
// into a 4-beat 64-bit burst on the memory side, and back.
//
// Handshake: read_i/write_i are level requests held until the one-cycle resp_o
// pulse. On the memory side each cycle with resp_i=1 while read_o/write_o is
// high transfers exactly one beat; resp_i=0 stalls with nothing changing.
module cacheline_adaptor #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4,
  localparam int LINE_W = BEAT_W * BEATS,
  localparam int BW     = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  input  logic              resp_i,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  localparam logic [31:0] OFF_MASK = 32'(LINE_W / 8 - 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d, beat_nxt;
  logic              last_beat;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [LINE_W-1:0] line_d;
  logic [31:0]       address_d;
  logic              resp_d, read_d, write_d;
  logic [BEAT_W-1:0] burst_d;

  assign beat_nxt  = beat_q + 1'b1;
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign state_dbg = state_q;

  // State and every output are flops; reset drops the memory request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      buf_q     <= '0;
      line_o    <= '0;
      resp_o    <= 1'b0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      burst_o   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      buf_q     <= buf_d;
      line_o    <= line_d;
      resp_o    <= resp_d;
      address_o <= address_d;
      read_o    <= read_d;
      write_o   <= write_d;
      burst_o   <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          state_d = WR;
          beat_d  = '0;
        end else if (read_i) begin
          state_d = RD;
          beat_d  = '0;
        end
      end
      RD, WR: begin
        if (resp_i) begin
          beat_d = beat_nxt;
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; write has priority over read in IDLE.
  always_comb begin
    address_d = address_o;
    read_d    = read_o;
    write_d   = write_o;
    burst_d   = burst_o;
    line_d    = line_o;
    resp_d    = 1'b0;
    buf_d     = buf_q;
    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          address_d = address_i & ~OFF_MASK;
          write_d   = 1'b1;
          buf_d     = line_i;
          burst_d   = line_i[BEAT_W-1:0];
        end else if (read_i) begin
          address_d = address_i & ~OFF_MASK;
          read_d    = 1'b1;
        end
      end
      RD: begin
        if (resp_i) begin
          buf_d[beat_q*BEAT_W +: BEAT_W] = burst_i;
          if (last_beat) begin
            read_d = 1'b0;
            resp_d = 1'b1;
            line_d = buf_d;
          end
        end
      end
      WR: begin
        if (resp_i) begin
          if (last_beat) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
          end else begin
            burst_d = buf_q[beat_nxt*BEAT_W +: BEAT_W];
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
Line-fill/writeback responder between the i-cache/d-cache controller and the arbiter/main-memory port. It accepts a 256-bit line read or write from the cache side and performs it as a 4-beat, 64-bit burst on the memory side. On reads it reassembles the beats into one line and returns it to the cache ways. On writes it serializes the dirty line into beats.

Parameters:
BEAT_W, 64, memory-side burst data width in bits.
BEATS, 4, beats per cache line. The line width is BEAT_W*BEATS = 256. The line offset is 5 bits.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
address_i  input  32  cache-side line address; bits [4:0] are ignored.
read_i  input  1  cache requests a line read; held until resp_o.
write_i  input  1  cache requests a line write; held until resp_o.
line_i  input  256  write line from the cache; sampled on acceptance.
line_o  output  256  assembled read line; valid while resp_o=1 and held until the next read completes.
resp_o  output  1  one-cycle completion pulse to the cache.
address_o  output  32  memory-side address, {latched addr[31:5], 5'b0}.
read_o  output  1  memory burst read request.
write_o  output  1  memory burst write request.
burst_o  output  64  current write beat.
burst_i  input  64  read beat from memory.
resp_i  input  1  memory accepted (write) or delivered (read) one beat this cycle.

Behaviour:
- All outputs are registered.
- Reset values: line_o=0, resp_o=0, address_o=0, read_o=0, write_o=0, burst_o=0. Internally, state=IDLE and beat count=0.
- Reset asserted mid-burst returns to IDLE immediately, drops read_o/write_o asynchronously, and discards partial beats.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - write_i=1 → latch address_i and line_i, go to WR, beat=0. write_i has priority when read_i=1 in the same cycle.
  - else read_i=1 → latch address_i, go to RD, beat=0.
  - else stay.
- RD:
  - read_o=1; address_o is stable for the whole burst.
  - Each cycle with resp_i=1: store burst_i into line bits [beat*64 +: 64] and increment beat.
  - resp_i=0 cycles stall with no change.
  - On the 4th beat: read_o←0, go to DONE.
- WR:
  - write_o=1; burst_o = latched line [beat*64 +: 64], beat 0 first (bits 63:0).
  - Each cycle with resp_i=1: advance beat and present the next beat on the following cycle.
  - On the 4th accepted beat: write_o←0, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle, then IDLE.
  - For reads, line_o updates in the same cycle resp_o rises.
  - read_i/write_i are ignored in DONE. The cache deasserts them on seeing resp_o.
  - A request still asserted in the following IDLE cycle is treated as a new request.
- Beat counter: 2 bits, wraps only via the state change; it is never incremented outside RD/WR.
- resp_i while in IDLE or DONE is ignored.
- A read_i/write_i change during RD/WR is ignored; the latched request completes.
- Minimum latency, request seen in cycle 0 with resp_i=1 every beat:
  - read_o/write_o high in cycles 1–4.
  - resp_o high in cycle 5.
  - Back in IDLE in cycle 6.
- read_o and write_o are never high simultaneously.
- line_o is unchanged by writes.

Test Plan:
- Read, no stalls: read_i with address_i=0x0000_1234; memory returns 0x1111…, 0x2222…, 0x3333…, 0x4444… (64-bit each). Required: address_o=0x0000_1220, read_o for 4 cycles, resp_o pulse in cycle 5, line_o={0x4444…,0x3333…,0x2222…,0x1111…}.
- Write with stalls: write_i with line_i=256'h…DDDD_CCCC_BBBB_AAAA-patterned beats (beat k = 64'hk…k), resp_i pattern 1,0,0,1,1,0,1. Required: burst_o holds each beat until accepted, beats are sent 0→3 in order, write_o drops after the 4th accept, then one resp_o.
- Simultaneous read_i=1 and write_i=1 in IDLE: required WR first (write_o=1, read_o=0); after resp_o, if read_i is still asserted, RD starts the following IDLE cycle.
- Reset mid-read after 2 beats: required read_o=0 immediately, line_o=0, resp_o never pulses. A fresh read afterwards returns the correct 4 new beats.
- Spurious resp_i=1 while IDLE, and read_i toggling during RD: required no state change in IDLE. The original read completes with its latched address.
- Back-to-back reads to 0x40 then 0x60 with the request held through resp_o: required exactly one resp_o per transaction, with a one-cycle IDLE gap between bursts.
